id_ex_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV64I core. Captures decoded ID fields and register-file read data each cycle.

---
 rtl/id_ex_reg_pkg.sv | 20 ++
 rtl/id_ex_reg_load_use_detect.sv | 29 ++
 rtl/id_ex_reg.sv | 154 +++++++++++++++
 tb/tb_id_ex_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared widths, control-bundle bit positions and the per-edge action type
// for the ID/EX pipeline register of the RV64I core.
package id_ex_reg_pkg;

    localparam int unsigned REG_DATA_WIDTH   = 64;
    localparam int unsigned REG_ADDR_WIDTH   = 5;
    localparam int unsigned CTRL_WIDTH       = 10;
    localparam int unsigned BUBBLE_CNT_WIDTH = 32;

    // Control bundle bit carrying "instruction reads data memory".
    localparam int unsigned CTRL_MEM_READ    = 1;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } ex_action_e;

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Combinational load-use hazard detector: a load sitting in EX whose
// destination is read by the valid instruction currently in ID.
module load_use_detect #(
    parameter int ADDR_W = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic              id_valid,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    output logic              load_use
);

    logic load_in_ex_s;
    logic rs1_dep_s;
    logic rs2_dep_s;

    // A load targeting x0 produces nothing to wait for, so it never stalls.
    always_comb begin
        load_in_ex_s = ex_valid & ex_mem_read & (ex_rd_addr != {ADDR_W{1'b0}});
        rs1_dep_s    = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
        rs2_dep_s    = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
        load_use     = load_in_ex_s & id_valid & (rs1_dep_s | rs2_dep_s);
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded ID fields, inserts load-use
// bubbles, honours EX hold and branch flush, and snoops writeback while held.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W = REG_DATA_WIDTH,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int CTRL_W = CTRL_WIDTH,
    parameter int CNT_W  = BUBBLE_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic [ADDR_W-1:0] id_rd_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs1_addr,
    output logic [ADDR_W-1:0] ex_rs2_addr,
    output logic [ADDR_W-1:0] ex_rd_addr,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid_r;
    logic [DATA_W-1:0] ex_pc_r;
    logic [DATA_W-1:0] ex_imm_r;
    logic [ADDR_W-1:0] ex_rs1_addr_r;
    logic [ADDR_W-1:0] ex_rs2_addr_r;
    logic [ADDR_W-1:0] ex_rd_addr_r;
    logic [DATA_W-1:0] ex_rs1_data_r;
    logic [DATA_W-1:0] ex_rs2_data_r;
    logic [CTRL_W-1:0] ex_ctrl_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic              load_use_s;
    ex_action_e        action_s;

    // Writes to x0 are architecturally discarded, so they must never be snooped.
    function automatic logic snoop_hit(input logic              we,
                                       input logic [ADDR_W-1:0] wrd,
                                       input logic [ADDR_W-1:0] rs);
        return we && (wrd != {ADDR_W{1'b0}}) && (wrd == rs);
    endfunction

    load_use_detect #(.ADDR_W(ADDR_W)) u_load_use_detect (
        .ex_valid    (ex_valid_r),
        .ex_mem_read (ex_ctrl_r[CTRL_MEM_READ]),
        .ex_rd_addr  (ex_rd_addr_r),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .load_use    (load_use_s)
    );

    // Resolve what this edge does: flush beats hold beats load-use bubble.
    always_comb begin
        action_s = ACT_LOAD;
        if (flush) begin
            action_s = ACT_FLUSH;
        end else if (ex_hold) begin
            action_s = ACT_HOLD;
        end else if (load_use_s) begin
            action_s = ACT_BUBBLE;
        end else begin
            action_s = ACT_LOAD;
        end
    end

    assign stall_id = ~flush & (ex_hold | load_use_s);

    // Pipeline register update, bubble counter and writeback snooping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_r    <= 1'b0;
            ex_pc_r       <= {DATA_W{1'b0}};
            ex_imm_r      <= {DATA_W{1'b0}};
            ex_rs1_addr_r <= {ADDR_W{1'b0}};
            ex_rs2_addr_r <= {ADDR_W{1'b0}};
            ex_rd_addr_r  <= {ADDR_W{1'b0}};
            ex_rs1_data_r <= {DATA_W{1'b0}};
            ex_rs2_data_r <= {DATA_W{1'b0}};
            ex_ctrl_r     <= {CTRL_W{1'b0}};
            bubble_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (action_s)
                ACT_FLUSH: begin
                    ex_valid_r <= 1'b0;
                    ex_ctrl_r  <= {CTRL_W{1'b0}};
                end
                ACT_HOLD: begin
                    if (snoop_hit(wb_reg_write, wb_rd_addr, ex_rs1_addr_r)) begin
                        ex_rs1_data_r <= wb_data;
                    end
                    if (snoop_hit(wb_reg_write, wb_rd_addr, ex_rs2_addr_r)) begin
                        ex_rs2_data_r <= wb_data;
                    end
                end
                ACT_BUBBLE: begin
                    ex_valid_r <= 1'b0;
                    ex_ctrl_r  <= {CTRL_W{1'b0}};
                    if (!(&bubble_cnt_r)) begin
                        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ACT_LOAD: begin
                    ex_valid_r    <= id_valid;
                    ex_pc_r       <= id_pc;
                    ex_imm_r      <= id_imm;
                    ex_rs1_addr_r <= id_rs1_addr;
                    ex_rs2_addr_r <= id_rs2_addr;
                    ex_rd_addr_r  <= id_rd_addr;
                    ex_rs1_data_r <= id_rs1_data;
                    ex_rs2_data_r <= id_rs2_data;
                    ex_ctrl_r     <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
                end
                default: begin
                    ex_valid_r <= 1'b0;
                    ex_ctrl_r  <= {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    assign ex_valid    = ex_valid_r;
    assign ex_pc       = ex_pc_r;
    assign ex_imm      = ex_imm_r;
    assign ex_rs1_addr = ex_rs1_addr_r;
    assign ex_rs2_addr = ex_rs2_addr_r;
    assign ex_rd_addr  = ex_rd_addr_r;
    assign ex_rs1_data = ex_rs1_data_r;
    assign ex_rs2_data = ex_rs2_data_r;
    assign ex_ctrl     = ex_ctrl_r;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed, table-driven bench for id_ex_reg; a second instance with a 2-bit
// bubble counter shares the stimulus to exercise counter saturation.
module tb_id_ex_reg;

    localparam logic [9:0] LD = 10'h003;
    localparam logic [9:0] AL = 10'h001;
    localparam logic [9:0] ZC = 10'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, flush, ex_hold, wb_reg_write;
    logic [9:0]  id_ctrl;

    logic        ex_valid, stall_id;
    logic [63:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [9:0]  ex_ctrl;
    logic [31:0] bubble_cnt;

    logic        c2_valid, c2_stall;
    logic [63:0] c2_pc, c2_imm, c2_rs1_data, c2_rs2_data;
    logic [4:0]  c2_rs1_addr, c2_rs2_addr, c2_rd_addr;
    logic [9:0]  c2_ctrl;
    logic [1:0]  c2_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_ctrl(ex_ctrl),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    id_ex_reg #(.CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .ex_valid(c2_valid), .ex_pc(c2_pc), .ex_imm(c2_imm),
        .ex_rs1_addr(c2_rs1_addr), .ex_rs2_addr(c2_rs2_addr), .ex_rd_addr(c2_rd_addr),
        .ex_rs1_data(c2_rs1_data), .ex_rs2_data(c2_rs2_data), .ex_ctrl(c2_ctrl),
        .stall_id(c2_stall), .bubble_cnt(c2_cnt)
    );

    // Operand/PC/immediate values are derived from register indices so a
    // stale or mis-latched field shows up as a different value.
    function automatic logic [63:0] d1(input logic [4:0] a);
        return {4'h1, 55'd0, a};
    endfunction
    function automatic logic [63:0] d2(input logic [4:0] a);
        return {4'h2, 55'd0, a};
    endfunction
    function automatic logic [63:0] pcof(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {49'd0, a, b, c};
    endfunction
    function automatic logic [63:0] immof(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {4'hF, 45'd0, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [9:0]  ctrl;
        logic        fl, hd, ww;
        logic [4:0]  wrd;
        logic [63:0] wd;
        logic        e_stall, e_v;
        logic [9:0]  e_ctrl;
        logic        chk;
        logic [4:0]  e_rs1a, e_rs2a, e_rda;
        logic [63:0] e_rs1d, e_rs2d;
        logic [31:0] e_cnt;
        logic [1:0]  e_cnt2;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input vec_t t);
        id_valid     = t.v;
        id_rs1_addr  = t.rs1;
        id_rs2_addr  = t.rs2;
        id_rd_addr   = t.rd;
        id_uses_rs1  = t.u1;
        id_uses_rs2  = t.u2;
        id_ctrl      = t.ctrl;
        id_rs1_data  = d1(t.rs1);
        id_rs2_data  = d2(t.rs2);
        id_pc        = pcof(t.rs1, t.rs2, t.rd);
        id_imm       = immof(t.rs1, t.rs2, t.rd);
        flush        = t.fl;
        ex_hold      = t.hd;
        wb_reg_write = t.ww;
        wb_rd_addr   = t.wrd;
        wb_data      = t.wd;
    endtask

    initial begin
        vec_t idle;
        idle = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ZC, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
                 1'b0, 1'b0, ZC, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 32'd0, 2'd0};
        drive(idle);

        // Reset for two cycles under random ID traffic.
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            id_valid    = 1'b1;
            id_rs1_addr = 5'($urandom);
            id_rs2_addr = 5'($urandom);
            id_rd_addr  = 5'($urandom);
            id_uses_rs1 = 1'b1;
            id_uses_rs2 = 1'b1;
            id_ctrl     = 10'($urandom);
            id_pc       = {$urandom, $urandom};
            id_rs1_data = {$urandom, $urandom};
            @(posedge clk); #1;
            chk($sformatf("reset%0d ex_valid", c), 64'(ex_valid), 64'd0);
            chk($sformatf("reset%0d ex_ctrl", c), 64'(ex_ctrl), 64'd0);
            chk($sformatf("reset%0d bubble_cnt", c), 64'(bubble_cnt), 64'd0);
            chk($sformatf("reset%0d stall_id", c), 64'(stall_id), 64'd0);
        end
        reset = 1'b0;

        //            v    rs1    rs2    rd     u1    u2    ctrl fl    hd    ww    wrd    wd          | stall ev   ectrl chk  rs1a   rs2a   rda    rs1d        rs2d        cnt     cnt2
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd5, 1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd5, d1(5'd2), d2(5'd0), 32'd0,2'd0});
        vq.push_back('{1'b1,5'd5, 5'd7, 5'd6, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b1,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd1,2'd1});
        vq.push_back('{1'b1,5'd5, 5'd7, 5'd6, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,AL, 1'b1,5'd5, 5'd7, 5'd6, d1(5'd5), d2(5'd7), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd1, 5'd0, 5'd0, 1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd1, 5'd0, 5'd0, d1(5'd1), d2(5'd0), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd0, 5'd7, 5'd6, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,AL, 1'b1,5'd0, 5'd7, 5'd6, d1(5'd0), d2(5'd7), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd3, 5'd4, 5'd8, 1'b1,1'b1,AL, 1'b0,1'b1,1'b1,5'd0, 64'hBAD,    1'b1,1'b1,AL, 1'b1,5'd0, 5'd7, 5'd6, d1(5'd0), d2(5'd7), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd3, 5'd4, 5'd8, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,AL, 1'b1,5'd3, 5'd4, 5'd8, d1(5'd3), d2(5'd4), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd9, 5'd0, 5'd10,1'b1,1'b0,AL, 1'b0,1'b1,1'b1,5'd5, 64'hBEEF,   1'b1,1'b1,AL, 1'b1,5'd3, 5'd4, 5'd8, d1(5'd3), d2(5'd4), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd9, 5'd0, 5'd10,1'b1,1'b0,AL, 1'b0,1'b1,1'b1,5'd3, 64'hDEAD,   1'b1,1'b1,AL, 1'b1,5'd3, 5'd4, 5'd8, 64'hDEAD, d2(5'd4), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd9, 5'd0, 5'd10,1'b1,1'b0,AL, 1'b0,1'b1,1'b1,5'd4, 64'hCAFE,   1'b1,1'b1,AL, 1'b1,5'd3, 5'd4, 5'd8, 64'hDEAD, 64'hCAFE, 32'd1,2'd1});
        vq.push_back('{1'b1,5'd9, 5'd0, 5'd10,1'b1,1'b0,AL, 1'b0,1'b1,1'b0,5'd3, 64'hBAD,    1'b1,1'b1,AL, 1'b1,5'd3, 5'd4, 5'd8, 64'hDEAD, 64'hCAFE, 32'd1,2'd1});
        vq.push_back('{1'b1,5'd9, 5'd0, 5'd10,1'b1,1'b0,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,AL, 1'b1,5'd9, 5'd0, 5'd10,d1(5'd9), d2(5'd0), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd11,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd11,d1(5'd2), d2(5'd0), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd1, 5'd11,5'd12,1'b1,1'b1,AL, 1'b1,1'b1,1'b0,5'd0, 64'd0,      1'b0,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd1,2'd1});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd12,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd12,d1(5'd2), d2(5'd0), 32'd1,2'd1});
        vq.push_back('{1'b1,5'd1, 5'd12,5'd6, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b1,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd2,2'd2});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd13,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd13,d1(5'd2), d2(5'd0), 32'd2,2'd2});
        vq.push_back('{1'b1,5'd13,5'd1, 5'd6, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b1,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd3,2'd3});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd14,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd14,d1(5'd2), d2(5'd0), 32'd3,2'd3});
        vq.push_back('{1'b1,5'd14,5'd1, 5'd6, 1'b1,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b1,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd4,2'd3});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd15,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd15,d1(5'd2), d2(5'd0), 32'd4,2'd3});
        vq.push_back('{1'b1,5'd15,5'd0, 5'd6, 1'b0,1'b1,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,AL, 1'b1,5'd15,5'd0, 5'd6, d1(5'd15),d2(5'd0), 32'd4,2'd3});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd16,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd16,d1(5'd2), d2(5'd0), 32'd4,2'd3});
        vq.push_back('{1'b0,5'd16,5'd0, 5'd6, 1'b1,1'b0,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b0,ZC, 1'b1,5'd16,5'd0, 5'd6, d1(5'd16),d2(5'd0), 32'd4,2'd3});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd17,1'b1,1'b0,LD, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd17,d1(5'd2), d2(5'd0), 32'd4,2'd3});
        vq.push_back('{1'b1,5'd17,5'd0, 5'd6, 1'b1,1'b0,AL, 1'b0,1'b1,1'b0,5'd0, 64'd0,      1'b1,1'b1,LD, 1'b1,5'd2, 5'd0, 5'd17,d1(5'd2), d2(5'd0), 32'd4,2'd3});
        vq.push_back('{1'b1,5'd17,5'd0, 5'd6, 1'b1,1'b0,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b1,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd5,2'd3});
        vq.push_back('{1'b1,5'd17,5'd0, 5'd6, 1'b1,1'b0,AL, 1'b0,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b1,AL, 1'b1,5'd17,5'd0, 5'd6, d1(5'd17),d2(5'd0), 32'd5,2'd3});
        vq.push_back('{1'b1,5'd2, 5'd0, 5'd18,1'b1,1'b0,LD, 1'b1,1'b0,1'b0,5'd0, 64'd0,      1'b0,1'b0,ZC, 1'b0,5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    32'd5,2'd3});

        foreach (vq[i]) begin
            drive(vq[i]);
            #1;
            chk($sformatf("row%0d stall_id", i), 64'(stall_id), 64'(vq[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("row%0d ex_valid", i), 64'(ex_valid), 64'(vq[i].e_v));
            chk($sformatf("row%0d ex_ctrl", i), 64'(ex_ctrl), 64'(vq[i].e_ctrl));
            chk($sformatf("row%0d bubble_cnt", i), 64'(bubble_cnt), 64'(vq[i].e_cnt));
            chk($sformatf("row%0d bubble_cnt_w2", i), 64'(c2_cnt), 64'(vq[i].e_cnt2));
            if (vq[i].chk) begin
                chk($sformatf("row%0d ex_rs1_addr", i), 64'(ex_rs1_addr), 64'(vq[i].e_rs1a));
                chk($sformatf("row%0d ex_rs2_addr", i), 64'(ex_rs2_addr), 64'(vq[i].e_rs2a));
                chk($sformatf("row%0d ex_rd_addr", i), 64'(ex_rd_addr), 64'(vq[i].e_rda));
                chk($sformatf("row%0d ex_rs1_data", i), ex_rs1_data, vq[i].e_rs1d);
                chk($sformatf("row%0d ex_rs2_data", i), ex_rs2_data, vq[i].e_rs2d);
                chk($sformatf("row%0d ex_pc", i), ex_pc,
                    pcof(vq[i].e_rs1a, vq[i].e_rs2a, vq[i].e_rda));
                chk($sformatf("row%0d ex_imm", i), ex_imm,
                    immof(vq[i].e_rs1a, vq[i].e_rs2a, vq[i].e_rda));
            end
        end

        // Reset must override a simultaneous valid load, hold and flush.
        id_valid = 1'b1; id_ctrl = LD; ex_hold = 1'b1; flush = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        chk("late_reset ex_valid", 64'(ex_valid), 64'd0);
        chk("late_reset ex_ctrl", 64'(ex_ctrl), 64'd0);
        chk("late_reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("late_reset bubble_cnt_w2", 64'(c2_cnt), 64'd0);
        chk("late_reset ex_rs1_data", ex_rs1_data, 64'd0);
        reset = 1'b0; flush = 1'b0; ex_hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
